// File: rtl/enc_pkg.sv
// Shared constants for the RV32I instruction encoder: opcodes, op-field positions, FSM states.
package enc_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned XLEN   = 32;

    // op group bits: [3] ALU class, [4] alternate (sub/sra or mem), [5] register/store/branch select
    localparam int unsigned OP_ALU_BIT = 3;
    localparam int unsigned OP_ALT_BIT = 4;
    localparam int unsigned OP_HI_BIT  = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when v is a sign-extended value of the given bit width.
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
        logic [XLEN-1:0] hi_mask;
        hi_mask = ~((XLEN'(1) << (bits - 1)) - XLEN'(1));
        return ((v & hi_mask) == '0) || ((v & hi_mask) == hi_mask);
    endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Combinational RV32I packer: descriptor -> instruction word plus illegal flag.
// Immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encode_comb
    import enc_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  word,
    output logic             illegal
);

    logic [2:0] f3;
    logic       alt;
    logic       range_ok;

    assign f3  = op[2:0];
    assign alt = op[OP_ALT_BIT];

    always_comb begin
        word     = '0;
        illegal  = 1'b0;
        range_ok = 1'b1;
        if (op == '0) begin
            word = '0;
        end else if (op[OP_ALU_BIT]) begin
            if (op[OP_HI_BIT]) begin
                illegal = alt && !((f3 == 3'b000) || (f3 == 3'b101));
                word    = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OPC_OP};
            end else if (op[1:0] == 2'b01) begin
                illegal  = alt && (f3 != 3'b101);
                range_ok = (imm[31:5] == '0);
                word     = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
            end else begin
                illegal  = alt;
                range_ok = fits_signed(imm, 12);
                word     = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
            end
        end else if (op[OP_ALT_BIT]) begin
            range_ok = fits_signed(imm, 12);
            if (!op[OP_HI_BIT]) begin
                illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                word    = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            end else begin
                illegal = f3[2] || (f3 == 3'b011);
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            end
        end else if (op[OP_HI_BIT]) begin
            illegal  = (f3 == 3'b010) || (f3 == 3'b011);
            range_ok = fits_signed(imm, 13) && !imm[0];
            word     = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
        end else begin
            case (f3)
                3'b100: begin
                    range_ok = fits_signed(imm, 12);
                    word     = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
                end
                3'b101: begin
                    range_ok = fits_signed(imm, 21) && !imm[0];
                    word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                end
                3'b010: begin
                    range_ok = (imm[11:0] == '0);
                    word     = {imm[31:12], rd, OPC_AUIPC};
                end
                3'b110: begin
                    range_ok = (imm[11:0] == '0);
                    word     = {imm[31:12], rd, OPC_LUI};
                end
                default: illegal = 1'b1;
            endcase
        end
`ifdef ENC_RANGE_CHECK_EN
        illegal = illegal || !range_ok;
`endif
        if (illegal) word = '0;
    end

`ifndef ENC_RANGE_CHECK_EN
    logic unused_range_ok;
    assign unused_range_ok = range_ok;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder and IMEM loader: packs descriptors and writes them at consecutive
// word addresses from base_addr. Optional immediate range checking: ENC_RANGE_CHECK_EN.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [XLEN-1:0]   in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_illegal,
    output logic              err_full
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(1) << ADDR_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_ill_q, err_ill_d;
    logic                err_full_q, err_full_d;

    logic [XLEN-1:0]     enc_word;
    logic                enc_illegal;
    logic                accept;

    instr_encode_comb u_enc (
        .op      (in_op),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign accept = in_valid && ready_q;

    // count tracks completed writes; ready also reserves a slot for the write in flight
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q + CNT_W'(we_q);
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_ill_d  = err_ill_q;
        err_full_d = err_full_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    addr_d     = base_addr;
                    count_d    = '0;
                    err_ill_d  = 1'b0;
                    err_full_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (enc_illegal) begin
                        err_ill_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = enc_word;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                    if (in_last) state_d = ST_FLUSH;
                end
                if (count_d == CAP) state_d = ST_DONE;
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        if (count_d == CAP) err_full_d = 1'b1;
        ready_d = (state_d == ST_RUN) && ((count_d + CNT_W'(we_d)) < CAP);
        busy_d  = (state_d == ST_RUN) || (state_d == ST_FLUSH);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_ill_q  <= 1'b0;
            err_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_ill_q  <= err_ill_d;
            err_full_q <= err_full_d;
        end
    end

    assign in_ready    = ready_q;
    assign imem_we     = we_q;
    assign imem_addr   = waddr_q;
    assign imem_wdata  = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign count       = count_q;
    assign err_illegal = err_ill_q;
    assign err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed programs, capacity/wrap, reset mid-run, random programs.
module tb_instr_encoder;

    localparam int unsigned AW  = 3;
    localparam int unsigned CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_ready, in_last;
    logic [AW-1:0] base_addr;
    logic [5:0]    in_op;
    logic [4:0]    in_rs1, in_rs2, in_rd;
    logic [31:0]   in_imm;
    logic          imem_we, busy, done, err_illegal, err_full;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .count(count),
        .err_illegal(err_illegal), .err_full(err_full)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];
    int  checks = 0, failures = 0;
    int  exp_addr, exp_count;
    bit  exp_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: classify the op into an instruction kind, then assemble fields arithmetically.
    function automatic void ref_encode(input logic [5:0] op, input logic [4:0] rs1, rs2, rd,
                                       input logic [31:0] imm, output logic [31:0] w, output bit ok);
        int unsigned f3;
        logic [31:0] r1, r2, d, f, i12, s12, b13, j21, u20;
        longint si;
        f3  = int'(op[2:0]);
        r1  = 32'(rs1) << 15;
        r2  = 32'(rs2) << 20;
        d   = 32'(rd) << 7;
        f   = 32'(f3) << 12;
        si  = longint'($signed(imm));
        i12 = (imm & 32'hFFF) << 20;
        s12 = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        b13 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
            | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
        j21 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
        u20 = imm & 32'hFFFFF000;
        ok = 1'b1;
        w  = 32'h0;
        if (op == 6'd0) begin
            w = 32'h0;
        end else if (op[3] && op[5]) begin
            ok = !op[4] || f3 == 0 || f3 == 5;
            w  = (op[4] ? 32'h4000_0000 : 32'h0) | r2 | r1 | f | d | 32'h33;
        end else if (op[3] && op[1:0] == 2'b01) begin
            ok = !op[4] || f3 == 5;
`ifdef ENC_RANGE_CHECK_EN
            if (imm > 31) ok = 1'b0;
`endif
            w = (op[4] ? 32'h4000_0000 : 32'h0) | ((imm & 32'h1F) << 20) | r1 | f | d | 32'h13;
        end else if (op[3]) begin
            ok = !op[4];
`ifdef ENC_RANGE_CHECK_EN
            if (si < -2048 || si > 2047) ok = 1'b0;
`endif
            w = i12 | r1 | f | d | 32'h13;
        end else if (op[4]) begin
            ok = op[5] ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
`ifdef ENC_RANGE_CHECK_EN
            if (si < -2048 || si > 2047) ok = 1'b0;
`endif
            w = op[5] ? (s12 | r2 | r1 | f | 32'h23) : (i12 | r1 | f | d | 32'h03);
        end else if (op[5]) begin
            ok = f3 != 2 && f3 != 3;
`ifdef ENC_RANGE_CHECK_EN
            if (si < -4096 || si > 4095 || imm[0]) ok = 1'b0;
`endif
            w = b13 | r2 | r1 | f | 32'h63;
        end else begin
            case (f3)
                4: w = i12 | r1 | d | 32'h67;
                5: w = j21 | d | 32'h6F;
                2: w = u20 | d | 32'h17;
                6: w = u20 | d | 32'h37;
                default: ok = 1'b0;
            endcase
`ifdef ENC_RANGE_CHECK_EN
            if (f3 == 4 && (si < -2048 || si > 2047)) ok = 1'b0;
            if (f3 == 5 && (si < -(64'sd1 << 20) || si >= (64'sd1 << 20) || imm[0])) ok = 1'b0;
            if ((f3 == 2 || f3 == 6) && imm[11:0] != 12'h0) ok = 1'b0;
`endif
        end
        if (!ok) w = 32'h0;
    endfunction

    // Monitor: every observed write must match the oldest expected write.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(imem_addr), e.addr);
                    chk("wr_data", imem_wdata, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err_illegal", 32'(err_illegal), 0);
        chk("rst_err_full", 32'(err_full), 0);
    endtask

    task automatic do_start(input int base);
        base_addr = AW'(base);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        exp_addr  = base;
        exp_count = 0;
        exp_ill   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [5:0] op, input logic [4:0] rs1, rs2, rd,
                        input logic [31:0] imm, input bit last,
                        input logic [31:0] word, input bit legal);
        int n = 0;
        wr_t e;
        in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
        in_last = last; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (legal) begin
            e.addr = 32'(exp_addr);
            e.data = word;
            exp_q.push_back(e);
            exp_addr  = (exp_addr + 1) % CAP;
            exp_count++;
        end else begin
            exp_ill = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_prog(input bit exp_full);
        int n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("done", 32'(done), 1);
        chk("count", 32'(count), 32'(exp_count));
        chk("err_illegal", 32'(err_illegal), 32'(exp_ill));
        chk("err_full", 32'(err_full), 32'(exp_full));
        chk("busy_at_done", 32'(busy), 0);
        chk("ready_at_done", 32'(in_ready), 0);
        chk("pending_writes", 32'(exp_q.size()), 0);
    endtask

    task automatic rand_desc(output logic [5:0] op, output logic [4:0] rs1, rs2, rd,
                             output logic [31:0] imm);
        logic [5:0] legal_ops [10] = '{6'b101000, 6'b111000, 6'b001000, 6'b011101, 6'b010010,
                                       6'b110001, 6'b100101, 6'b000101, 6'b000110, 6'b000100};
        op  = ($urandom_range(0, 1) == 0) ? legal_ops[$urandom_range(0, 9)] : 6'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
        imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) - 32'd2048 : $urandom;
    endtask

    initial begin : stim
        logic [5:0]  op;
        logic [4:0]  r1, r2, rd;
        logic [31:0] imm, w;
        bit          ok;
        int          len;
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);

        // add/sub program at base 4
        do_start(4);
        send(6'b101000, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h002081B3, 1'b1);
        send(6'b111000, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h402081B3, 1'b1);
        finish_prog(1'b0);

        // mixed formats, an illegal op, address wrap, and a start pulse ignored in RUN
        do_start(6);
        send(6'b001000, 5'd0, 5'd7, 5'd1, 32'hFFFFFFFF, 1'b0, 32'hFFF00093, 1'b1);
        send(6'b000110, 5'd3, 5'd9, 5'd5, 32'h12345000, 1'b0, 32'h123452B7, 1'b1);
        base_addr = '0;
        start = 1'b1;
        send(6'b100000, 5'd1, 5'd2, 5'd31, 32'h8, 1'b0, 32'h00208463, 1'b1);
        start = 1'b0;
        send(6'b000001, 5'd4, 5'd4, 5'd4, 32'h0, 1'b0, 32'h0, 1'b0);
        send(6'b110010, 5'd1, 5'd2, 5'd13, 32'h4, 1'b1, 32'h0020A223, 1'b1);
        finish_prog(1'b0);

        // capacity: base 2, writes wrap 2..7,0,1 then in_ready drops
        do_start(2);
        for (int i = 0; i < CAP; i++) begin
            r1 = 5'(i); r2 = 5'(i + 1); rd = 5'(i + 2);
            ref_encode(6'b101000, r1, r2, rd, 32'h0, w, ok);
            send(6'b101000, r1, r2, rd, 32'h0, 1'b0, w, ok);
        end
        chk("ready_low_when_full", 32'(in_ready), 0);
        in_op = 6'b101000; in_valid = 1'b1;
        finish_prog(1'b1);
        in_valid = 1'b0;

        // reset the cycle after a handshake drops state and the next write strobe
        do_start(5);
        send(6'b101000, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h002081B3, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);

        // random programs with occasional idle gaps
        for (int p = 0; p < 16; p++) begin
            do_start(int'($urandom_range(0, CAP - 1)));
            len = int'($urandom_range(1, CAP - 1));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                rand_desc(op, r1, r2, rd, imm);
                ref_encode(op, r1, r2, rd, imm, w, ok);
                send(op, r1, r2, rd, imm, i == len - 1, w, ok);
            end
            finish_prog(1'b0);
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
